// File: rtl/link_pkg.sv
// Shared definitions for the player-character link controller and its datapath.
// State encoding, direction codes and the direction priority helper live here.
package link_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_IDLE   = 3'd3,
    ST_ATTACK = 3'd4,
    ST_MOVE   = 3'd5,
    ST_DRAW   = 3'd6
  } state_t;

  // Direction codes are also decoded by the character datapath.
  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  // Opposing buttons resolve as up > down > left > right.
  function automatic dir_t pick_dir(input logic up, input logic down,
                                    input logic left, input logic right);
    dir_t d;
    d = DIR_RIGHT;
    if (up)        d = DIR_UP;
    else if (down) d = DIR_DOWN;
    else if (left) d = DIR_LEFT;
    else if (right) d = DIR_RIGHT;
    return d;
  endfunction

endpackage

// File: rtl/link_frame_sched.sv
// One-deep frame tick buffer: remembers a tick that arrives while the FSM is busy
// and pulses frame_overrun when a second tick has nowhere to go.
module link_frame_sched
  import link_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic frame_tick,
  input  logic accept,
  output logic pending,
  output logic frame_overrun
);

  always_ff @(posedge clock) begin
    if (reset) begin
      pending       <= OFF;
      frame_overrun <= OFF;
    end else begin
      frame_overrun <= OFF;
      if (accept) begin
        // A decide driven by the buffered tick re-buffers a coincident fresh tick.
        pending <= pending & frame_tick;
      end else if (frame_tick) begin
        if (pending) frame_overrun <= ON;
        else         pending       <= ON;
      end
    end
  end

endmodule

// File: rtl/link_control.sv
// Per-frame sequencer for the player-character datapath: decides attack / move / idle
// once per frame, then holds draw_char until the datapath reports draw_done or times out.
module link_control
  import link_pkg::*;
#(
  parameter int ATTACK_FRAMES = 8,
  parameter int MOVE_DIV      = 1,
  parameter int DRAW_TIMEOUT  = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic frame_tick,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_attack,
  input  logic draw_done,
  output logic init,
  output logic idle,
  output logic attack,
  output logic move_up,
  output logic move_down,
  output logic move_left,
  output logic move_right,
  output logic draw_char,
  output logic busy,
  output logic frame_overrun,
  output logic draw_error
);

  localparam logic [7:0] ATK_RELOAD = 8'(ATTACK_FRAMES - 1);
  localparam logic [3:0] STEP_LAST  = 4'(MOVE_DIV - 1);
  localparam logic [9:0] TIMER_LAST = 10'(DRAW_TIMEOUT - 1);

  state_t      state;
  dir_t        move_dir;
  logic [7:0]  atk_cnt;
  logic [3:0]  step_cnt;
  logic [9:0]  timer;
  logic        last_attack;
  logic        pending;
  logic        decide;
  logic        any_dir;
  logic        sched_tick;

  assign any_dir    = btn_up | btn_down | btn_left | btn_right;
  assign decide     = (state == ST_WAIT) && (frame_tick || pending);
  assign sched_tick = frame_tick && (state != ST_RESET);

  link_frame_sched u_sched (
    .clock         (clock),
    .reset         (reset),
    .frame_tick    (sched_tick),
    .accept        (decide),
    .pending       (pending),
    .frame_overrun (frame_overrun)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_RESET;
      move_dir    <= DIR_UP;
      atk_cnt     <= '0;
      step_cnt    <= '0;
      timer       <= '0;
      last_attack <= OFF;
      draw_error  <= OFF;
    end else begin
      case (state)
        ST_RESET: if (start) state <= ST_INIT;
        ST_INIT, ST_IDLE, ST_ATTACK, ST_MOVE: begin
          state <= ST_DRAW;
          timer <= '0;
        end
        ST_DRAW: begin
          if (draw_done) begin
            state <= ST_WAIT;
          end else if (timer == TIMER_LAST) begin
            draw_error <= ON;
            state      <= ST_WAIT;
          end else begin
            timer <= timer + 10'd1;
          end
        end
        ST_WAIT: begin
          if (decide) begin
            last_attack <= btn_attack;
            // Attack frames leave step_cnt untouched so movement resumes where it left off.
            if (atk_cnt != 8'd0) begin
              state   <= ST_ATTACK;
              atk_cnt <= atk_cnt - 8'd1;
            end else if (btn_attack && !last_attack) begin
              state   <= ST_ATTACK;
              atk_cnt <= ATK_RELOAD;
            end else if (any_dir && step_cnt == STEP_LAST) begin
              state    <= ST_MOVE;
              step_cnt <= '0;
              move_dir <= pick_dir(btn_up, btn_down, btn_left, btn_right);
            end else begin
              state    <= ST_IDLE;
              step_cnt <= any_dir ? step_cnt + 4'd1 : 4'd0;
            end
          end
        end
        default: state <= ST_RESET;
      endcase
    end
  end

  assign init       = (state == ST_INIT);
  assign idle       = (state == ST_IDLE);
  assign attack     = (state == ST_ATTACK);
  assign move_up    = (state == ST_MOVE) && (move_dir == DIR_UP);
  assign move_down  = (state == ST_MOVE) && (move_dir == DIR_DOWN);
  assign move_left  = (state == ST_MOVE) && (move_dir == DIR_LEFT);
  assign move_right = (state == ST_MOVE) && (move_dir == DIR_RIGHT);
  assign draw_char  = (state == ST_DRAW);
  assign busy       = (state != ST_RESET) && (state != ST_WAIT);

endmodule
